tx_gearbox_130b: RTL and testbench
==================================

// Module: tx_gearbox_130b
// PURPOSE
//  Gen3 128b/130b TX gearbox, directly downstream of the TX scrambler, one per lane.
//  Consumes 32-bit scrambled words, 4 per block, plus the block sync header.
//  Emits a packed 32-bit bitstream toward the PIPE TX datapath.
//  Inserts the 2-bit sync header at each block start.
//  Absorbs 16 headers (32 bits) by stalling the input one cycle per 16 blocks (65 out / 64 in).
// PARAMETERS
//  WORDS_PER_BLOCK  4   32-bit words per 128-bit block (fixed; not overridable)
//  BLOCKS_PER_SET   16  blocks between input stalls (fixed; not overridable)
// PORTS
//  pclk       in   1   PIPE clock
//  reset      in   1   synchronous, active-high reset
//  gen3_en    in   1   1: gearbox active (GEN>=3); 0: bypass
//  in_valid   in   1   scrambled word valid (scramblerDataValid)
//  in_ready   out  1   gearbox accepts in_data this cycle
//  in_data    in   32  scrambled word (scramblerDataOut)
//  in_sync    in   2   block sync header; sampled only on a block's first word
//  out_valid  out  1   out_data valid
//  out_data   out  32  packed stream; bit0 is transmitted first
//  sync_err   out  1   1-cycle pulse: sampled in_sync not 2'b01/2'b10
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, sync_err=0, acc=0, r=0, word_idx=0.
//   Combinational in_ready is 1 after reset (r=0).
//  State: acc[63:0] residual bits; r = residual count, even, 0..32; word_idx 0..3.
//  Accept: accept = in_valid & in_ready.
//   word_idx advances mod 4 on accept only; it is not advanced on stall or idle cycles.
//  On accept with word_idx==0: new = {in_data, in_sync} (34 bits); otherwise new = in_data (32 bits).
//   in_sync[0] is sent first.
//  Packing: nxt = acc | (new << r).
//   Registered outputs: out_data <= nxt[31:0], acc <= nxt >> 32, out_valid <= 1.
//   r <= r+2 if a header was inserted, else r unchanged.
//  in_ready is combinational: in_ready = gen3_en ? !(r==32 && word_idx==0) : 1.
//  Stall cycle (gen3_en=1, r==32, word_idx==0):
//   out_data <= acc[31:0], out_valid <= 1, r <= 0, acc <= 0.
//   The stall cycle is independent of in_valid.
//  Idle (no accept, no stall): out_valid <= 0; acc, r, word_idx, out_data hold.
//  Latency: 1 cycle from accept to the corresponding out_valid.
//  Width bound: r + 34 <= 64, so acc never overflows.
//  sync_err <= 1 for one cycle when a word_idx==0 accept has in_sync in {00,11}; the data still passes.
//  Bypass (gen3_en=0): out_data <= in_data, out_valid <= in_valid, no header insertion.
//   acc, r and word_idx are forced to 0, so re-enabling starts a clean set.
//  gen3_en toggles are legal only at block boundaries; mid-block toggles drop residual bits.
//  Reset asserted mid-set discards residual bits.
//   The next accepted word is treated as a block start with r=0.
// TESTING
//  1. Reset asserted -> out_valid=0, out_data=0, sync_err=0, in_ready=1 next cycle.
//  2. gen3_en=1, in_sync=01, 4 words 0xFFFFFFFF -> outs 0xFFFFFFFD, 0xFFFFFFFF x3; r=2.
//  3. 16 back-to-back blocks (64 words), in_valid held 1:
//     in_ready=0 exactly on cycle 65; 65 out words; r=0 after;
//     last out = 32 residual bits.
//  4. in_valid dropped 3 cycles mid-block -> out_valid=0 for 3 cycles.
//     The bitstream equals the no-gap case.
//  5. in_sync=11 on block start -> sync_err=1 for exactly one cycle; data still packed.
//  6. gen3_en=0, in_data=0xA5A5A5A5, in_valid=1 -> next-cycle out_data=0xA5A5A5A5.
//     in_ready stays 1.
//     Separately, reset mid-set after 7 blocks -> next block restarts with r=0.

Source files
------------

// File: rtl/tx_gearbox_130b.sv
// 128b/130b TX gearbox: packs sync header + 4 scrambled words per block into a 32-bit stream, 1-cycle latency.
// Backpressure: in_ready drops for one cycle every 16 blocks to flush 32 accumulated header bits.
module tx_gearbox_130b (
  input  logic        pclk,
  input  logic        reset,
  input  logic        gen3_en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_sync,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        sync_err
);

  logic [63:0] acc;
  logic [5:0]  r;
  logic [1:0]  word_idx;

  logic        stall;
  logic        accept;
  logic        hdr;
  logic [63:0] new_bits;
  logic [63:0] nxt;

  always_comb begin
    stall    = gen3_en && (r == 6'd32) && (word_idx == 2'd0);
    in_ready = gen3_en ? !((r == 6'd32) && (word_idx == 2'd0)) : 1'b1;
    accept   = in_valid && in_ready;
    hdr      = (word_idx == 2'd0);
    // in_sync[0] lands at the lowest bit so it is transmitted first
    new_bits = hdr ? {30'd0, in_data, in_sync} : {32'd0, in_data};
    nxt      = acc | (new_bits << r);
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      acc       <= 64'd0;
      r         <= 6'd0;
      word_idx  <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      sync_err  <= 1'b0;
    end else if (!gen3_en) begin
      acc       <= 64'd0;
      r         <= 6'd0;
      word_idx  <= 2'd0;
      out_valid <= in_valid;
      out_data  <= in_data;
      sync_err  <= 1'b0;
    end else if (stall) begin
      // residual holds exactly one full word of absorbed headers
      out_data  <= acc[31:0];
      out_valid <= 1'b1;
      acc       <= 64'd0;
      r         <= 6'd0;
      sync_err  <= 1'b0;
    end else if (accept) begin
      out_data  <= nxt[31:0];
      out_valid <= 1'b1;
      acc       <= nxt >> 32;
      r         <= hdr ? r + 6'd2 : r;
      word_idx  <= word_idx + 2'd1;
      sync_err  <= hdr && ((in_sync == 2'b00) || (in_sync == 2'b11));
    end else begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_gearbox_130b.sv
// Directed bench for tx_gearbox_130b: vector table plus bit-queue reference for multi-block sequences.
module tb_tx_gearbox_130b;

  logic        pclk = 1'b0;
  logic        reset;
  logic        gen3_en;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_sync;
  logic        out_valid;
  logic [31:0] out_data;
  logic        sync_err;

  int n_tests = 0;
  int n_fail  = 0;

  bit q[$];
  int m_widx;

  always #5 pclk = ~pclk;

  tx_gearbox_130b dut (
    .pclk      (pclk),
    .reset     (reset),
    .gen3_en   (gen3_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sync   (in_sync),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sync_err  (sync_err)
  );

  typedef struct {
    logic        rst;
    logic        gen;
    logic        vld;
    logic [31:0] dat;
    logic [1:0]  sync;
    logic        chk_rdy;
    logic        exp_rdy;
    logic        exp_ov;
    logic [31:0] exp_od;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, gen, vld, input logic [31:0] dat, input logic [1:0] sync,
                              input logic chk_rdy, exp_rdy, exp_ov, input logic [31:0] exp_od, input logic exp_err);
    vec_t v;
    v.rst = rst; v.gen = gen; v.vld = vld; v.dat = dat; v.sync = sync;
    v.chk_rdy = chk_rdy; v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_od = exp_od; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs just after a rising edge, sample in_ready before the next edge, return 1 ns after it.
  task automatic cycle(input logic rst, input logic gen, input logic vld, input logic [31:0] dat,
                       input logic [1:0] sync, output logic rdy);
    reset = rst; gen3_en = gen; in_valid = vld; in_data = dat; in_sync = sync;
    #2;
    rdy = in_ready;
    @(posedge pclk);
    #1;
  endtask

  task automatic model_push(input logic [31:0] d, input logic [1:0] s);
    if (m_widx == 0) begin
      q.push_back(s[0]);
      q.push_back(s[1]);
    end
    for (int i = 0; i < 32; i++) q.push_back(d[i]);
    m_widx = (m_widx + 1) % 4;
  endtask

  task automatic check_out_word(input string name);
    logic [31:0] w;
    w = 32'd0;
    if (q.size() < 32) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got word %h with only %0d reference bits pending", name, out_data, q.size());
    end else begin
      for (int i = 0; i < 32; i++) w[i] = q.pop_front();
      chk(name, out_data, w);
    end
  endtask

  function automatic logic [31:0] word_of(input int k, input logic [31:0] seed);
    return (k * 32'h9E3779B9) ^ seed;
  endfunction

  task automatic drive_words(input int nwords, input int gap_at, input int gap_len, input logic [31:0] seed,
                             output int stall_cnt, output int stall_pos, output int nout, output int idle_gap);
    int  k;
    int  gap;
    bit  tail;
    bit  in_gap;
    logic v, rdy;
    logic [31:0] d;
    logic [1:0]  s;
    k = 0; gap = 0; tail = 0;
    stall_cnt = 0; stall_pos = -1; nout = 0; idle_gap = 0;
    for (int cyc = 0; cyc < nwords + gap_len + 8; cyc++) begin
      if (k >= nwords) begin
        if (tail) break;
        tail = 1;
      end
      in_gap = (k < nwords) && (k == gap_at) && (gap < gap_len);
      if (in_gap) gap++;
      v = (k < nwords) && !in_gap;
      d = word_of(k, seed);
      s = ((k / 4) % 2 == 1) ? 2'b10 : 2'b01;
      cycle(1'b0, 1'b1, v, d, s, rdy);
      if (!rdy) begin
        stall_cnt++;
        stall_pos = cyc;
      end
      if (v && rdy) begin
        model_push(d, s);
        k++;
      end
      if (in_gap && !out_valid) idle_gap++;
      if (out_valid) begin
        check_out_word($sformatf("stream_w%0d", nout));
        nout++;
      end
    end
    chk("words_accepted", k, nwords);
  endtask

  initial begin
    logic rdy;
    int sc, sp, no, ig;

    // rst gen vld dat sync | chk_rdy rdy ov od err
    vecs.push_back(mk(1, 1, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        0)); // reset
    vecs.push_back(mk(0, 1, 0, 32'h0,        2'b00, 1, 1, 0, 32'h0,        0)); // idle after reset
    vecs.push_back(mk(0, 1, 1, 32'hFFFFFFFF, 2'b01, 1, 1, 1, 32'hFFFFFFFD, 0));
    vecs.push_back(mk(0, 1, 1, 32'hFFFFFFFF, 2'b01, 1, 1, 1, 32'hFFFFFFFF, 0));
    vecs.push_back(mk(0, 1, 1, 32'hFFFFFFFF, 2'b01, 1, 1, 1, 32'hFFFFFFFF, 0));
    vecs.push_back(mk(0, 1, 1, 32'hFFFFFFFF, 2'b01, 1, 1, 1, 32'hFFFFFFFF, 0));
    vecs.push_back(mk(0, 1, 1, 32'h0,        2'b11, 1, 1, 1, 32'h0000000F, 1)); // bad header
    vecs.push_back(mk(0, 1, 1, 32'h0,        2'b11, 1, 1, 1, 32'h0,        0)); // sync ignored mid-block
    vecs.push_back(mk(0, 1, 0, 32'h0,        2'b00, 1, 1, 0, 32'h0,        0));
    vecs.push_back(mk(0, 1, 1, 32'h0,        2'b00, 1, 1, 1, 32'h0,        0));
    vecs.push_back(mk(0, 1, 1, 32'h0,        2'b00, 1, 1, 1, 32'h0,        0));
    vecs.push_back(mk(0, 0, 1, 32'hA5A5A5A5, 2'b00, 1, 1, 1, 32'hA5A5A5A5, 0)); // bypass
    vecs.push_back(mk(0, 0, 0, 32'h12345678, 2'b11, 1, 1, 0, 32'h12345678, 0));
    vecs.push_back(mk(0, 1, 1, 32'hFFFFFFFF, 2'b10, 1, 1, 1, 32'hFFFFFFFE, 0)); // clean restart
    vecs.push_back(mk(0, 1, 1, 32'h0,        2'b00, 1, 1, 1, 32'h00000003, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        2'b00, 1, 1, 0, 32'h00000003, 0)); // idle holds data
    vecs.push_back(mk(0, 1, 1, 32'h0,        2'b00, 1, 1, 1, 32'h0,        0));
    vecs.push_back(mk(0, 1, 1, 32'h0,        2'b00, 1, 1, 1, 32'h0,        0));

    reset = 1'b1; gen3_en = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_sync = 2'b00;
    @(posedge pclk);
    #1;

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].gen, vecs[i].vld, vecs[i].dat, vecs[i].sync, rdy);
      if (vecs[i].chk_rdy) chk($sformatf("vec%0d_in_ready", i), rdy, vecs[i].exp_rdy);
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
      chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_od);
      chk($sformatf("vec%0d_sync_err", i), sync_err, vecs[i].exp_err);
    end

    // Full set of 16 blocks back-to-back: one stall, 65 output words, nothing left over
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 2'b00, rdy);
    q.delete();
    m_widx = 0;
    drive_words(64, -1, 0, 32'h3C5A_0F96, sc, sp, no, ig);
    chk("set_stall_count", sc, 1);
    chk("set_stall_cycle", sp, 64);
    chk("set_out_words", no, 65);
    chk("set_residual_bits", q.size(), 0);

    // Mid-block gap of 3 cycles; starting right after the stall also confirms r returned to 0
    drive_words(8, 6, 3, 32'h5555_AAAA, sc, sp, no, ig);
    chk("gap_idle_cycles", ig, 3);
    chk("gap_stall_count", sc, 0);
    chk("gap_out_words", no, 8);

    // Reset after 7 more blocks: residual discarded, next block starts with r=0
    drive_words(28, -1, 0, 32'h0BAD_F00D, sc, sp, no, ig);
    cycle(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 2'b01, rdy);
    q.delete();
    m_widx = 0;
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_out_data", out_data, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 2'b10, rdy);
    chk("rst_mid_in_ready", rdy, 1'b1);
    chk("rst_mid_w0", out_data, 32'hFFFFFFFE);
    cycle(1'b0, 1'b1, 1'b1, 32'h00000000, 2'b00, rdy);
    chk("rst_mid_w1", out_data, 32'h00000003);
    cycle(1'b0, 1'b1, 1'b1, 32'h80000000, 2'b00, rdy);
    chk("rst_mid_w2", out_data, 32'h00000000);
    cycle(1'b0, 1'b1, 1'b1, 32'h00000000, 2'b00, rdy);
    chk("rst_mid_w3", out_data, 32'h00000002);
    chk("rst_mid_w3_valid", out_valid, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
